// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl -- memory-mapped interrupt controller
//
// Purpose
//   Collects up to NUM_SRC interrupt source lines into a PENDING register,
//   masks them with ENABLE, and presents the lowest-index active source to
//   the core as a single interrupt request with an ID.  The core claims the
//   interrupt by reading CLAIM and completes it by writing the claimed ID
//   back to CLAIM.  Interrupts are not preemptive: while one is in service,
//   new arrivals wait in PENDING.
//
// Register map (only addr_i[3:0] decoded, all accesses full-word)
//   0x0 ENABLE  RW  [NUM_SRC-1:0] per-source enable
//   0x4 PENDING RO  [NUM_SRC-1:0] pending sources
//   0x8 CLAIM   read  = claim the current candidate (returns its ID, 0 if none)
//               write = complete; data_i[4:0] must match the in-service ID
//   0xC STATUS  RO  [1:0] FSM state, [12:8] in-service ID
//   Other offsets read 0 and ignore writes.
//
// IDs: source i has ID i+1; ID 0 means "no interrupt".
//
// Configuration
//   IRQ_CTRL_EDGE_EN defined   : edge mode. PENDING[i] sets on a rising edge
//                                of irq_src_i[i] and clears only on claim.
//   IRQ_CTRL_EDGE_EN undefined : level mode (default). PENDING follows the
//                                source lines; the device must drop its line.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   req_i      in   bus request
//   we_i       in   write enable (1 = write, 0 = read)
//   addr_i     in   [31:0] address
//   data_i     in   [31:0] write data
//   wem        in   byte mask, ignored (all writes are full-word)
//   addr_ok    out  request accepted (combinational echo of req_i)
//   data_ok    out  response valid, one cycle after each request
//   data_o     out  [31:0] registered read data
//   irq_src_i  in   [NUM_SRC-1:0] interrupt source lines
//   int_req_o  out  interrupt request to the core
//   int_id_o   out  [4:0] ID of the requested source, 0 when none
// ============================================================================

`ifndef RAM_MASK_WIDTH
`define RAM_MASK_WIDTH 4
`endif

module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                data_i,
    input  logic [`RAM_MASK_WIDTH-1:0] wem,
    output logic                       addr_ok,
    output logic                       data_ok,
    output logic [31:0]                data_o,
    input  logic [NUM_SRC-1:0]         irq_src_i,
    output logic                       int_req_o,
    output logic [4:0]                 int_id_o
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [3:0] OFF_ENABLE  = 4'h0;
    localparam logic [3:0] OFF_PENDING = 4'h4;
    localparam logic [3:0] OFF_CLAIM   = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [NUM_SRC-1:0] enable_q,  enable_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [4:0]         srv_id_q,  srv_id_d;
    logic [31:0]        data_o_q,  data_o_d;
    logic               data_ok_q, data_ok_d;
`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] src_hist_q, src_hist_d;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0] offs;
    logic       wr_en;
    logic       rd_en;
    logic       sel_enable;
    logic       sel_claim;

    assign offs       = addr_i[3:0];
    assign wr_en      = req_i & we_i;
    assign rd_en      = req_i & ~we_i;
    assign sel_enable = (offs == OFF_ENABLE);
    assign sel_claim  = (offs == OFF_CLAIM);

    // Address, upper data bits and byte mask carry no meaning here; folding
    // them into one named net documents that they are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{wem, addr_i[31:4], data_i};

    // ------------------------------------------------------------------
    // Candidate selection: lowest-index source that is pending and enabled
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] active;
    logic               cand_valid;
    logic [4:0]         cand_id;

    assign active = pending_q & enable_q;

    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch results.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = 5'd0;
        // Walk from the top down so the lowest set index is written last
        // and therefore wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                cand_valid = 1'b1;
                cand_id    = 5'(i + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Claim / complete qualifiers
    // ------------------------------------------------------------------
    logic claim_take;   // CLAIM read that actually hands out an interrupt
    logic complete;     // CLAIM write that ends the current service

    assign claim_take = rd_en & sel_claim & (state_q == ST_REQ) & cand_valid;
    assign complete   = wr_en & sel_claim & (state_q == ST_SERVICE)
                      & (data_i[4:0] == srv_id_q);

    // ------------------------------------------------------------------
    // Pending capture
    // ------------------------------------------------------------------
`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand_mask;
    logic [NUM_SRC-1:0] claim_clr;

    assign rise      = irq_src_i & ~src_hist_q;
    // Isolate the lowest set bit: the one-hot form of the candidate.
    assign cand_mask = active & (~active + NUM_SRC'(1));
    assign claim_clr = claim_take ? cand_mask : '0;

    always_comb begin
        src_hist_d = irq_src_i;
        // A rising edge in the same cycle as the claim re-arms the bit, so
        // OR-ing the edge in after the clear gives the set priority.
        pending_d  = (pending_q & ~claim_clr) | rise;
    end
`else
    // Level mode: pending mirrors the lines; a claim only records the ID
    // and the device is expected to drop its request itself.
    always_comb begin
        pending_d = irq_src_i;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic: FSM, registers, bus response
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        srv_id_d  = srv_id_q;
        data_o_d  = data_o_q;
        data_ok_d = req_i;      // every accepted request gets one response
        rd_data   = 32'd0;

        // Register writes (ENABLE is the only writable storage register)
        if (wr_en && sel_enable) begin
            enable_d = data_i[NUM_SRC-1:0];
        end

        // Read mux; undefined offsets fall through to 0
        case (offs)
            OFF_ENABLE:  rd_data = 32'(enable_q);
            OFF_PENDING: rd_data = 32'(pending_q);
            OFF_CLAIM:   rd_data = (state_q == ST_REQ && cand_valid)
                                   ? 32'(cand_id) : 32'd0;
            OFF_STATUS:  rd_data = {19'd0, srv_id_q, 6'd0, state_q};
            default:     rd_data = 32'd0;
        endcase

        // Writes leave the last read value on data_o
        if (rd_en) begin
            data_o_d = rd_data;
        end

        // In-service ID: latched on claim, dropped on completion so STATUS
        // shows no stale ID once the controller is idle again.
        if (claim_take) begin
            srv_id_d = cand_id;
        end else if (complete) begin
            srv_id_d = 5'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Losing the candidate (disabled or level dropped) withdraws
                // the request before any claim is considered.
                if (!cand_valid) begin
                    state_d = ST_IDLE;
                end else if (claim_take) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // Going straight to REQ lets a waiting interrupt be
                // requested in the cycle right after the completion.
                if (complete) begin
                    state_d = cand_valid ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            enable_q   <= '0;
            pending_q  <= '0;
            srv_id_q   <= 5'd0;
            data_o_q   <= 32'd0;
            data_ok_q  <= 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
            src_hist_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            srv_id_q   <= srv_id_d;
            data_o_q   <= data_o_d;
            data_ok_q  <= data_ok_d;
`ifdef IRQ_CTRL_EDGE_EN
            src_hist_q <= src_hist_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign addr_ok = req_i;
    assign data_ok = data_ok_q;
    assign data_o  = data_o_q;

    // Gated by rst_n so the core sees no request while reset is held,
    // even before the reset edge has cleared the state register.
    assign int_req_o = rst_n & (state_q == ST_REQ);
    assign int_id_o  = int_req_o ? cand_id : 5'd0;

endmodule

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// tb_irq_ctrl -- self-checking bench for irq_ctrl (NUM_SRC = 8)
//
// Register accesses go through bus_read/bus_write; each one pushes an entry
// into a scoreboard queue and a negedge monitor pops one entry per data_ok,
// comparing data_o on reads.  A table of register vectors covers decode
// corners; hand-written sequences cover the multi-cycle interrupt flows.
// Expectations hold in both edge and level builds; the one sequence that
// needs a fresh edge during a claim only toggles the line in edge mode.
// ============================================================================

`ifndef RAM_MASK_WIDTH
`define RAM_MASK_WIDTH 4
`endif

module tb_irq_ctrl;

    localparam int NSRC = 8;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       req_i;
    logic                       we_i;
    logic [31:0]                addr_i;
    logic [31:0]                data_i;
    logic [`RAM_MASK_WIDTH-1:0] wem;
    logic                       addr_ok;
    logic                       data_ok;
    logic [31:0]                data_o;
    logic [NSRC-1:0]            irq_src_i;
    logic                       int_req_o;
    logic [4:0]                 int_id_o;

    irq_ctrl #(.NUM_SRC(NSRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .wem       (wem),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .data_o    (data_o),
        .irq_src_i (irq_src_i),
        .int_req_o (int_req_o),
        .int_id_o  (int_id_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        chk;    // 1 = read, compare data_o
        logic [31:0] exp;
        logic [31:0] addr;
    } sb_t;

    sb_t sb[$];
    sb_t sb_e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One scoreboard entry is consumed per response cycle.
    always @(negedge clk) begin
        if (data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL data_ok_unexpected: got data_ok=1 expected 0 at %0t", $time);
            end else begin
                sb_e = sb.pop_front();
                if (sb_e.chk)
                    check($sformatf("read_off_0x%0h", sb_e.addr[3:0]), data_o, sb_e.exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
        sb_t e;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        data_i = 32'd0;
        e.chk  = 1'b1;
        e.exp  = exp;
        e.addr = a;
        sb.push_back(e);
        tick();
        req_i  = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        e.chk  = 1'b0;
        e.exp  = 32'd0;
        e.addr = a;
        sb.push_back(e);
        tick();
        req_i  = 1'b0;
        we_i   = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic req, input logic [4:0] id);
        check({name, "_int_req"}, 32'(int_req_o), 32'(req));
        check({name, "_int_id"},  32'(int_id_o),  32'(id));
    endtask

    // ------------------------------------------------------------------
    // Register decode vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFA5, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_00A5};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h0000_00FF, 32'h0};   // RO
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0};   // RO
        vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'h1000_0000, 32'h0000_003C, 32'h0};   // aliases 0x0
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_003C};
        vecs[8]  = '{1'b1, 32'h0000_0006, 32'h0000_00FF, 32'h0};   // undefined
        vecs[9]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_003C};
        vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0};   // claim in IDLE
        vecs[12] = '{1'b1, 32'h0000_0008, 32'h0,         32'h0};   // complete in IDLE
        vecs[13] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 32'h0000_0000, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0};

        // -------------------------- reset ------------------------------
        rst_n     = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = 32'd0;
        data_i    = 32'd0;
        wem       = '1;
        irq_src_i = '0;
        tick();
        tick();
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_data_o",  data_o,       32'd0);
        check_irq("rst", 1'b0, 5'd0);
        rst_n = 1'b1;
        tick();

        // ------------------------ decode table -------------------------
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
            else            bus_read(vecs[i].addr, vecs[i].exp);
        end
        check("addr_ok_idle", 32'(addr_ok), 32'd0);
        check_irq("decode_quiet", 1'b0, 5'd0);

        // ------------- single source: request, claim, status -----------
        bus_write(32'h0, 32'h01);
        irq_src_i[0] = 1'b1;
        tick();
        tick();
        check_irq("src0_req", 1'b1, 5'd1);
        bus_read(32'h8, 32'd1);
        check_irq("src0_claimed", 1'b0, 5'd0);
        irq_src_i[0] = 1'b0;
        bus_read(32'hC, 32'h0000_0102);
        bus_read(32'h4, 32'h0);

        // ---------------- claim in SERVICE, wrong-ID complete -----------
        bus_read(32'h8, 32'd0);
        bus_write(32'h8, 32'd4);
        bus_read(32'hC, 32'h0000_0102);
        bus_write(32'h8, 32'd1);
        check_irq("complete1", 1'b0, 5'd0);
        bus_read(32'hC, 32'h0);

        // ------------- priority, no preemption, back-to-back ------------
        bus_write(32'h0, 32'hFF);
        irq_src_i = 8'b0010_0100;
        tick();
        tick();
        check_irq("prio", 1'b1, 5'd3);
        bus_read(32'h8, 32'd3);
        irq_src_i[2] = 1'b0;
        check_irq("no_preempt", 1'b0, 5'd0);
        tick();
        bus_read(32'h4, 32'h20);
        bus_write(32'h8, 32'd3);
        check_irq("rereq_next_cycle", 1'b1, 5'd6);
        bus_read(32'h8, 32'd6);
        irq_src_i[5] = 1'b0;
        tick();
        bus_write(32'h8, 32'd6);
        check_irq("prio_done", 1'b0, 5'd0);
        bus_read(32'hC, 32'h0);

        // ----------- new request on source 0 during its claim ----------
        irq_src_i[0] = 1'b1;
        tick();
        tick();
        check_irq("same_cycle_req", 1'b1, 5'd1);
`ifdef IRQ_CTRL_EDGE_EN
        irq_src_i[0] = 1'b0;
        tick();
        irq_src_i[0] = 1'b1;    // rising edge lands on the claim edge
`endif
        bus_read(32'h8, 32'd1);
        check_irq("same_cycle_service", 1'b0, 5'd0);
        bus_read(32'h4, 32'h01);
        bus_write(32'h8, 32'd1);
        check_irq("same_cycle_reenter", 1'b1, 5'd1);
        bus_read(32'h8, 32'd1);
        irq_src_i[0] = 1'b0;
        tick();
        bus_write(32'h8, 32'd1);
        bus_read(32'hC, 32'h0);

        // --------------- disabled source stays pending -----------------
        bus_write(32'h0, 32'h0);
        irq_src_i[3] = 1'b1;
        tick();
        tick();
        check_irq("disabled", 1'b0, 5'd0);
        bus_read(32'h4, 32'h08);
        bus_write(32'h0, 32'h08);
        tick();
        check_irq("reenabled", 1'b1, 5'd4);
        bus_read(32'h8, 32'd4);
        irq_src_i[3] = 1'b0;
        tick();
        bus_write(32'h8, 32'd4);
        bus_read(32'hC, 32'h0);

        // ------------------- reset during SERVICE ----------------------
        bus_write(32'h0, 32'h01);
        irq_src_i[0] = 1'b1;
        tick();
        tick();
        check_irq("pre_rst", 1'b1, 5'd1);
        bus_read(32'h8, 32'd1);
        rst_n        = 1'b0;
        irq_src_i[0] = 1'b0;
        req_i        = 1'b1;     // request swallowed by reset, no response
        we_i         = 1'b0;
        addr_i       = 32'hC;
        tick();
        rst_n = 1'b1;
        req_i = 1'b0;
        check("midrst_data_ok", 32'(data_ok), 32'd0);
        check("midrst_data_o",  data_o,       32'd0);
        check_irq("midrst", 1'b0, 5'd0);
        bus_read(32'hC, 32'h0);
        bus_read(32'h0, 32'h0);
        bus_read(32'h4, 32'h0);

        // --------------- request masked while rst_n is low -------------
        bus_write(32'h0, 32'h01);
        irq_src_i[0] = 1'b1;
        tick();
        tick();
        check_irq("req_before_rst", 1'b1, 5'd1);
        rst_n = 1'b0;
        #1;
        check_irq("req_during_rst", 1'b0, 5'd0);
        irq_src_i[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        check_irq("req_after_rst", 1'b0, 5'd0);
        bus_read(32'hC, 32'h0);

        // ---------------------------- wrap-up --------------------------
        tick();
        tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (1..31).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  1  bus request
- we_i  in  1  write enable
- addr_i  in  32  address; only [3:0] decoded
- data_i  in  32  write data
- wem  in  `RAM_MASK_WIDTH  byte mask; ignored, all writes full-word
- addr_ok  out  1  address accepted
- data_ok  out  1  response valid
- data_o  out  32  read data, registered
- irq_src_i  in  NUM_SRC  source lines (timer int_sig_o on bit 0)
- int_req_o  out  1  interrupt request to core
- int_id_o  out  5  ID of the requested source; 0 = none

Function
REQ-003 SHALL drive addr_ok = req_i combinationally, and assert data_ok for exactly one cycle, the cycle after each accepted req_i.
REQ-004 SHALL decode registers: 0x0 ENABLE (RW, bits [NUM_SRC-1:0]), 0x4 PENDING (RO), 0x8 CLAIM (read = claim, write = complete), 0xC STATUS (RO: [1:0] FSM state, [12:8] in-service ID).
REQ-005 SHALL return 0 on reads of undefined offsets, ignore writes to them and to RO registers, and read unused upper bits as 0.
REQ-006 SHALL map source i to ID i+1, with ID 0 meaning none.
REQ-007 SHALL select the lowest-index source with pending&enable set as the candidate, combinationally.
REQ-008 SHALL implement FSM IDLE(0) -> REQ(1) -> SERVICE(2).
- IDLE -> REQ when a candidate exists.
- REQ -> SERVICE on a CLAIM read.
- REQ -> IDLE when no candidate remains.
- SERVICE -> IDLE on a CLAIM write whose data_i[4:0] equals the in-service ID.
REQ-009 SHALL drive int_req_o=1 only in REQ, with int_id_o = the candidate ID; otherwise int_req_o=0 and int_id_o=0.
REQ-010 SHALL, on a CLAIM read in REQ, return the candidate ID, clear its pending bit, and latch it as the in-service ID, all in the same clock edge.
REQ-011 SHALL, on a CLAIM read outside REQ, return 0 with no state change.
REQ-012 SHALL ignore a CLAIM write whose ID mismatches, or that arrives outside SERVICE.
REQ-013 SHALL give a pending-set event priority over a claim-clear of the same bit in the same cycle, so the bit stays 1.
REQ-014 SHALL keep pending bits of disabled sources set; they become candidates once re-enabled.
REQ-015 SHALL not preempt: new candidates wait in pending while in SERVICE.
REQ-016 SHALL accept a completion in cycle N and be able to re-enter REQ in cycle N+1.

Reset
REQ-017 SHALL, while rst_n=0 at a clk edge, clear ENABLE, PENDING, the in-service ID, the edge-history flops, data_o and data_ok, and put the FSM in IDLE.
REQ-018 SHALL drive int_req_o=0 and int_id_o=0 during reset.
REQ-019 SHALL, on reset asserted mid-service, abandon the service with no completion required.

Configuration
REQ-020 SHALL support macro IRQ_CTRL_EDGE_EN.
- Defined: pending bit i is set on a rising edge of irq_src_i[i], detected against a 1-cycle history flop; it is cleared only by claim.
- Undefined: pending bit i follows irq_src_i[i] each cycle (level mode); a claim only records the in-service ID, and the source must be deasserted at the device.

Verification
REQ-021 SHALL cover the directed scenarios below:
- Write ENABLE=0x01, pulse irq_src_i[0] -> int_req_o=1 and int_id_o=1 within 2 cycles.
- CLAIM read in REQ -> data_o=1 on the data_ok cycle; int_req_o=0 the next cycle; STATUS=0x0102.
- Sources 2 and 5 pending with ENABLE=0xFF -> claim returns 3; after complete with 3, the next claim returns 6.
- Complete with wrong ID 4 while in service of 1 -> STATUS unchanged; complete with 1 -> IDLE.
- New edge on source 0 in the same cycle as its claim (edge mode) -> PENDING[0]=1 afterwards and REQ re-entered after completion.
- rst_n=0 for 1 cycle while in SERVICE -> FSM IDLE, all registers 0, int_req_o=0, data_ok=0.
